rgb_pwm_driver: RTL and testbench

Converts the 24-bit colour word chosen by the colour multiplexer into three pulse-width-modulated LED drive lines (red, green, blue). It sits directly downstream of the multiplexer: the multiplexer's `out[23:0]` feeds `colour[23:0]` here, and the three outputs go to the board's RGB LED pins. Duty values are latched once per PWM period, so colour changes never glitch mid-period.

---
 rtl/rgb_pkg.sv | 19 +
 rtl/rgb_pwm_driver_channel.sv | 37 +++
 rtl/rgb_pwm_driver.sv | 107 ++++++++++
 tb/tb_rgb_pwm_driver.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// Shared constants and state encoding for the RGB PWM driver.
// Channel byte positions follow the packed colour word used by the upstream multiplexer.
package rgb_pkg;

   localparam logic [7:0] PWM_MAX = 8'd254;

   localparam int R_MSB = 23;
   localparam int R_LSB = 16;
   localparam int G_MSB = 15;
   localparam int G_LSB = 8;
   localparam int B_MSB = 7;
   localparam int B_LSB = 0;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/rgb_pwm_driver_channel.sv
// One PWM colour channel: duty register loaded on a strobe, compare and output flop.
// The compare uses the counter's and duty's next values so the LED flop lines up with the period pulse.
module pwm_channel (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear,
   input  logic       load,
   input  logic [7:0] din,
   input  logic [7:0] cnt_next,
   output logic       led
);

   logic [7:0] duty_r;
   logic [7:0] duty_next_s;

   // Duty value in effect after this edge
   always_comb begin
      duty_next_s = duty_r;
      if (load) begin
         duty_next_s = din;
      end else begin
         duty_next_s = duty_r;
      end
   end

   // Duty register and registered compare output
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         duty_r <= 8'd0;
         led    <= 1'b0;
      end else begin
         duty_r <= duty_next_s;
         led    <= (cnt_next < duty_next_s);
      end
   end

endmodule

// File: rtl/rgb_pwm_driver.sv
// Three-channel RGB PWM driver: FSM, prescaler, shared 255-tick period counter and period pulse.
// Duties are reloaded only at period boundaries so colour changes never glitch mid-period.
module rgb_pwm_driver
   import rgb_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [23:0] colour,
   input  logic        enable,
   output logic        led_r,
   output logic        led_g,
   output logic        led_b,
   output logic        period_start
);

   localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

   state_t      state_r;
   state_t      state_next_s;
   logic [15:0] pre_cnt_r;
   logic [15:0] pre_next_s;
   logic [7:0]  pwm_cnt_r;
   logic [7:0]  pwm_next_s;
   logic        clear_s;
   logic        start_s;
   logic        tick_s;
   logic        wrap_s;
   logic        load_s;

   // Next state, counter updates and duty-load strobe
   always_comb begin
      clear_s      = rst | ~enable;
      start_s      = ~clear_s & (state_r == IDLE);
      tick_s       = ~clear_s & (state_r == RUN) & (pre_cnt_r == PRE_LAST);
      wrap_s       = tick_s & (pwm_cnt_r == PWM_MAX);
      load_s       = start_s | wrap_s;
      state_next_s = state_r;
      pre_next_s   = pre_cnt_r;
      pwm_next_s   = pwm_cnt_r;

      case (state_r)
         IDLE:    state_next_s = clear_s ? IDLE : RUN;
         RUN:     state_next_s = clear_s ? IDLE : RUN;
         default: state_next_s = IDLE;
      endcase

      // Disable wins over a coincident wrap, so no load happens then
      if (clear_s || start_s) begin
         pre_next_s = 16'd0;
         pwm_next_s = 8'd0;
      end else if (tick_s) begin
         pre_next_s = 16'd0;
         pwm_next_s = wrap_s ? 8'd0 : (pwm_cnt_r + 8'd1);
      end else begin
         pre_next_s = pre_cnt_r + 16'd1;
         pwm_next_s = pwm_cnt_r;
      end
   end

   // State, counters and period pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         pre_cnt_r    <= 16'd0;
         pwm_cnt_r    <= 8'd0;
         period_start <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         pre_cnt_r    <= pre_next_s;
         pwm_cnt_r    <= pwm_next_s;
         period_start <= load_s;
      end
   end

   pwm_channel u_red (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear_s),
      .load     (load_s),
      .din      (colour[R_MSB:R_LSB]),
      .cnt_next (pwm_next_s),
      .led      (led_r)
   );

   pwm_channel u_green (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear_s),
      .load     (load_s),
      .din      (colour[G_MSB:G_LSB]),
      .cnt_next (pwm_next_s),
      .led      (led_g)
   );

   pwm_channel u_blue (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear_s),
      .load     (load_s),
      .din      (colour[B_MSB:B_LSB]),
      .cnt_next (pwm_next_s),
      .led      (led_b)
   );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed testbench for rgb_pwm_driver with PRESCALE=1 and PRESCALE=4 instances.
// Inputs are shared; each scenario starts from a reset so both instances are in a known state.
module tb_rgb_pwm_driver;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable = 1'b0;
   logic [23:0] colour = 24'h000000;
   logic        led_r1, led_g1, led_b1, ps1;
   logic        led_r4, led_g4, led_b4, ps4;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   rgb_pwm_driver #(.PRESCALE(1)) dut1 (
      .clk(clk), .rst(rst), .colour(colour), .enable(enable),
      .led_r(led_r1), .led_g(led_g1), .led_b(led_b1), .period_start(ps1)
   );

   rgb_pwm_driver #(.PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .colour(colour), .enable(enable),
      .led_r(led_r4), .led_g(led_g4), .led_b(led_b4), .period_start(ps4)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // rst pulse; the step after return is the IDLE->RUN transition edge when enable=1
   task automatic restart(input logic [23:0] c);
      colour = c;
      enable = 1'b1;
      rst    = 1'b1;
      step();
      rst    = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b1; colour = 24'hFFFFFF;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({led_r1, led_g1, led_b1, ps1, led_r4, led_g4, led_b4, ps4} !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold cycle %0d got %b expected 00000000", i,
                     {led_r1, led_g1, led_b1, ps1, led_r4, led_g4, led_b4, ps4});
         end
      end
      rst = 1'b0;
      step();
      checks++;
      if ({ps1, led_r1, led_g1, led_b1} !== 4'b1111) begin
         errors++;
         $display("FAIL reset_first_pulse got %b expected 1111", {ps1, led_r1, led_g1, led_b1});
      end
      checks++;
      if ({ps4, led_r4} !== 2'b11) begin
         errors++;
         $display("FAIL reset_first_pulse_p4 got %b expected 11", {ps4, led_r4});
      end
   endtask

   task automatic test_duty_basic();
      int rc = 0, gc = 0, bc = 0, rbad = 0, psbad = 0;
      restart(24'h8000FF);
      for (int i = 0; i < 255; i++) begin
         rc += int'(led_r1); gc += int'(led_g1); bc += int'(led_b1);
         if (led_r1 !== (i < 128)) rbad++;
         if (ps1 !== (i == 0)) psbad++;
         step();
      end
      checks++; if (rc !== 128) begin errors++; $display("FAIL basic_red_count got %0d expected 128", rc); end
      checks++; if (gc !== 0) begin errors++; $display("FAIL basic_green_count got %0d expected 0", gc); end
      checks++; if (bc !== 255) begin errors++; $display("FAIL basic_blue_count got %0d expected 255", bc); end
      checks++; if (rbad !== 0) begin errors++; $display("FAIL basic_red_align got %0d bad cycles expected 0", rbad); end
      checks++; if (psbad !== 0) begin errors++; $display("FAIL basic_ps_pattern got %0d bad cycles expected 0", psbad); end
      checks++; if ({ps1, led_r1} !== 2'b11) begin errors++; $display("FAIL basic_next_period got %b expected 11", {ps1, led_r1}); end
   endtask

   task automatic test_colour_change();
      int rc1 = 0, rc2 = 0, gc2 = 0, bc2 = 0, rises = 0;
      logic prev = 1'b0;
      restart(24'h101010);
      for (int i = 0; i < 510; i++) begin
         if (i == 50) colour = 24'hF0F0F0;
         if (i == 255) begin
            checks++;
            if (ps1 !== 1'b1) begin errors++; $display("FAIL change_ps got %b expected 1", ps1); end
         end
         if (i < 255) rc1 += int'(led_r1);
         else begin rc2 += int'(led_r1); gc2 += int'(led_g1); bc2 += int'(led_b1); end
         if (led_r1 && !prev) rises++;
         prev = led_r1;
         step();
      end
      checks++; if (rc1 !== 16) begin errors++; $display("FAIL change_old_period got %0d expected 16", rc1); end
      checks++; if (rc2 !== 240) begin errors++; $display("FAIL change_new_red got %0d expected 240", rc2); end
      checks++; if (gc2 !== 240) begin errors++; $display("FAIL change_new_green got %0d expected 240", gc2); end
      checks++; if (bc2 !== 240) begin errors++; $display("FAIL change_new_blue got %0d expected 240", bc2); end
      checks++; if (rises !== 2) begin errors++; $display("FAIL change_red_edges got %0d expected 2", rises); end
   endtask

   task automatic test_enable_drop();
      restart(24'hFFFFFF);
      repeat (100) step();
      checks++; if (led_r1 !== 1'b1) begin errors++; $display("FAIL drop_before got %b expected 1", led_r1); end
      enable = 1'b0;
      step();
      checks++;
      if ({led_r1, led_g1, led_b1, ps1} !== 4'b0000) begin
         errors++; $display("FAIL drop_outputs got %b expected 0000", {led_r1, led_g1, led_b1, ps1});
      end
      colour = 24'h000002;
      step();
      checks++;
      if ({led_r1, led_g1, led_b1, ps1} !== 4'b0000) begin
         errors++; $display("FAIL drop_idle got %b expected 0000", {led_r1, led_g1, led_b1, ps1});
      end
      enable = 1'b1;
      step();
      checks++;
      if ({ps1, led_r1, led_g1, led_b1} !== 4'b1001) begin
         errors++; $display("FAIL reenable_first got %b expected 1001", {ps1, led_r1, led_g1, led_b1});
      end
      step();
      checks++; if ({ps1, led_b1} !== 2'b01) begin errors++; $display("FAIL reenable_second got %b expected 01", {ps1, led_b1}); end
      step();
      checks++; if (led_b1 !== 1'b0) begin errors++; $display("FAIL reenable_third got %b expected 0", led_b1); end
   endtask

   task automatic test_prescale();
      int rc = 0, gc = 0, bc = 0, pc = 0, rbad = 0;
      restart(24'h01FE00);
      for (int i = 0; i < 1020; i++) begin
         rc += int'(led_r4); gc += int'(led_g4); bc += int'(led_b4); pc += int'(ps4);
         if (led_r4 !== (i < 4)) rbad++;
         step();
      end
      checks++; if (rc !== 4) begin errors++; $display("FAIL p4_red got %0d expected 4", rc); end
      checks++; if (gc !== 1016) begin errors++; $display("FAIL p4_green got %0d expected 1016", gc); end
      checks++; if (bc !== 0) begin errors++; $display("FAIL p4_blue got %0d expected 0", bc); end
      checks++; if (pc !== 1) begin errors++; $display("FAIL p4_ps_count got %0d expected 1", pc); end
      checks++; if (rbad !== 0) begin errors++; $display("FAIL p4_red_align got %0d bad cycles expected 0", rbad); end
      checks++; if ({ps4, led_r4} !== 2'b11) begin errors++; $display("FAIL p4_period got %b expected 11", {ps4, led_r4}); end
   endtask

   task automatic test_reset_mid();
      restart(24'hFFFFFF);
      repeat (20) step();
      checks++; if (led_g1 !== 1'b1) begin errors++; $display("FAIL midrst_before got %b expected 1", led_g1); end
      colour = 24'h020202;
      rst = 1'b1;
      step();
      checks++;
      if ({led_r1, led_g1, led_b1, ps1} !== 4'b0000) begin
         errors++; $display("FAIL midrst_outputs got %b expected 0000", {led_r1, led_g1, led_b1, ps1});
      end
      step();
      rst = 1'b0;
      step();
      checks++; if ({ps1, led_g1} !== 2'b11) begin errors++; $display("FAIL midrst_restart got %b expected 11", {ps1, led_g1}); end
      step();
      checks++; if ({ps1, led_g1} !== 2'b01) begin errors++; $display("FAIL midrst_cnt1 got %b expected 01", {ps1, led_g1}); end
      step();
      checks++; if (led_g1 !== 1'b0) begin errors++; $display("FAIL midrst_cnt2 got %b expected 0", led_g1); end
   endtask

   initial begin
      test_reset();
      test_duty_basic();
      test_colour_change();
      test_enable_drop();
      test_prescale();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
